// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ AXI-Stream command requesters onto one
// I2C master command stream and routes returned read data to the last burst owner.
module axis_i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int RDATA_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [RDATA_WIDTH-1:0]        i2c_rdata_i,
  input  logic                          rvalid_i,
  output logic [RDATA_WIDTH-1:0]        rdata_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [15:0]          stall_q, stall_d;
  logic                 timeout_q, timeout_d;
  logic                 owned_q, owned_d;

  logic                 win_found_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [DATA_WIDTH-1:0] g_tdata_s;
  logic                 g_tvalid_s;
  logic                 g_tlast_s;
  logic                 xfer_s;
  logic                 hs_s;

  // Round-robin search starting just after the previous winner, wrapping around.
  always_comb begin
    logic [IDX_W:0] cand;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end else begin
        cand = cand;
      end
      if (!win_found_s && s_axis_tvalid[cand[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the owner's stream signals; owner_q equals the granted index during a burst.
  always_comb begin
    g_tdata_s  = '0;
    g_tvalid_s = 1'b0;
    g_tlast_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        g_tdata_s  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_tvalid_s = s_axis_tvalid[i];
        g_tlast_s  = s_axis_tlast[i];
      end else begin
        g_tdata_s  = g_tdata_s;
      end
    end
  end

  assign xfer_s = (state_q == S_XFER);
  assign hs_s   = xfer_s && g_tvalid_s && m_axis_tready;

  assign m_axis_tdata  = g_tdata_s;
  assign m_axis_tvalid = xfer_s && g_tvalid_s;
  assign m_axis_tlast  = xfer_s && g_tlast_s;
  assign s_axis_tready = (xfer_s && m_axis_tready) ? grant_q : '0;

  assign rdata_o   = i2c_rdata_i;
  assign rvalid_o  = owned_q ? (NUM_REQ'(rvalid_i) << owner_q) : '0;
  assign grant_o   = grant_q;
  assign busy_o    = xfer_s;
  assign timeout_o = timeout_q;

  // Next-state logic: grant in IDLE, burst tracking and stall abort in XFER.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    stall_d   = stall_q;
    timeout_d = 1'b0;
    owned_d   = owned_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d = S_XFER;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
          owner_d = win_idx_s;
          owned_d = 1'b1;
          stall_d = 16'd0;
        end else begin
          grant_d = '0;
        end
      end
      S_XFER: begin
        if (hs_s) begin
          stall_d = 16'd0;
          if (g_tlast_s) begin
            state_d = S_IDLE;
            grant_d = '0;
            last_d  = owner_q;
          end else begin
            state_d = S_XFER;
          end
        end else if (!g_tvalid_s) begin
          // Only an idle requester counts as stalled; downstream backpressure does not.
          if (stall_q == STALL_LIMIT) begin
            state_d   = S_IDLE;
            grant_d   = '0;
            last_d    = owner_q;
            stall_d   = 16'd0;
            timeout_d = 1'b1;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end else begin
          stall_d = stall_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        stall_d = 16'd0;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      stall_q   <= 16'd0;
      timeout_q <= 1'b0;
      owned_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
      owned_q   <= owned_d;
    end
  end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed self-checking bench for axis_i2c_arbiter with 4 requesters and default parameters.
module tb_axis_i2c_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic [63:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [7:0]  rdata_i;
  logic        rvalid_i;
  logic [7:0]  rdata_o;
  logic [3:0]  rvalid_o;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int bad;
  logic [3:0] exp_g;

  axis_i2c_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(16), .RDATA_WIDTH(8), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk_i(clk), .arst_i(arst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .i2c_rdata_i(rdata_i), .rvalid_i(rvalid_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    s_tdata[i*16 +: 16] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1; m_tready = 1'b1; rvalid_i = 1'b1; rdata_i = 8'h33;
    s_tvalid = 4'hF; s_tlast = 4'hF;
    for (int i = 0; i < 4; i++) set_data(i, 16'h1000 + 16'(i));
    tick(); tick(); #3;
    chk("rst_grant", grant, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_tready", s_tready, 4'h0);
    chk("rst_mvalid", m_tvalid, 1'b0);
    chk("rst_rvalid", rvalid_o, 4'h0);

    // release; first IDLE cycle, no burst granted yet
    tick(); arst = 1'b0; #3;
    chk("rvalid_no_owner", rvalid_o, 4'h0);
    chk("idle_grant", grant, 4'h0);
    chk("idle_tready", s_tready, 4'h0);
    rvalid_i = 1'b0;

    // round robin: order 0,1,2,3,0 with one IDLE cycle between beats
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick(); #3;
      chk("rr_grant", grant, exp_g);
      chk("rr_tdata", m_tdata, 16'h1000 + 16'(k % 4));
      chk("rr_tlast", m_tlast, 1'b1);
      chk("rr_tready", s_tready, exp_g);
      tick();
      if (k == 4) s_tvalid = 4'h0;
      #3;
      chk("rr_gap_grant", grant, 4'h0);
      chk("rr_gap_mvalid", m_tvalid, 1'b0);
    end

    // grant hold: 3-beat burst on requester 1 while requester 0 waits
    s_tvalid = 4'b0011; s_tlast = 4'b0001;
    set_data(0, 16'hB000); set_data(1, 16'hA001);
    tick(); #3;
    chk("hold_grant1", grant, 4'b0010);
    chk("hold_beat1", m_tdata, 16'hA001);
    chk("hold_tlast1", m_tlast, 1'b0);
    tick(); set_data(1, 16'hA002); #3;
    chk("hold_grant2", grant, 4'b0010);
    chk("hold_beat2", m_tdata, 16'hA002);
    chk("hold_tlast2", m_tlast, 1'b0);
    tick(); set_data(1, 16'hA003); s_tlast = 4'b0011; #3;
    chk("hold_grant3", grant, 4'b0010);
    chk("hold_beat3", m_tdata, 16'hA003);
    chk("hold_tlast3", m_tlast, 1'b1);
    tick(); s_tvalid = 4'b0001; #3;
    chk("hold_gap", grant, 4'h0);
    tick(); #3;
    chk("hold_next_grant", grant, 4'b0001);
    chk("hold_next_data", m_tdata, 16'hB000);
    tick(); s_tvalid = 4'h0; #3;
    chk("hold_end", grant, 4'h0);

    // backpressure: 5000 cycles of m_tready=0 never count as stall
    m_tready = 1'b0; s_tvalid = 4'b0100; s_tlast = 4'b0100; set_data(2, 16'hC002);
    tick(); #3;
    chk("bp_grant", grant, 4'b0100);
    chk("bp_tready_low", s_tready, 4'h0);
    chk("bp_mvalid", m_tvalid, 1'b1);
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(); #3;
      if (timeout !== 1'b0 || m_tdata !== 16'hC002 || grant !== 4'b0100 || m_tvalid !== 1'b1)
        bad++;
    end
    chk("bp_stable_cycles_bad", 64'(bad), 64'd0);
    m_tready = 1'b1; #1;
    chk("bp_tready_rise", s_tready, 4'b0100);
    tick(); s_tvalid = 4'h0; rvalid_i = 1'b1; rdata_i = 8'h5A; #3;
    chk("bp_done_grant", grant, 4'h0);
    chk("bp_done_timeout", timeout, 1'b0);
    chk("rd_route_rvalid", rvalid_o, 4'b0100);
    chk("rd_route_rdata", rdata_o, 8'h5A);

    // timeout: requester 2 sends one beat without tlast, then goes silent
    tick(); rvalid_i = 1'b0;
    s_tvalid = 4'b0100; s_tlast = 4'b0000; set_data(2, 16'hD002); #3;
    chk("rd_route_off", rvalid_o, 4'h0);
    tick(); #3;
    chk("to_grant", grant, 4'b0100);
    chk("to_beat_tlast", m_tlast, 1'b0);
    tick(); s_tvalid = 4'b1000; s_tlast = 4'b1000; set_data(3, 16'hE003); #3;
    bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      if (timeout !== 1'b0 || grant !== 4'b0100 || m_tvalid !== 1'b0) bad++;
      tick(); #3;
    end
    chk("to_stall_cycles_bad", 64'(bad), 64'd0);
    chk("to_pulse", timeout, 1'b1);
    chk("to_idle_grant", grant, 4'h0);
    chk("to_idle_busy", busy, 1'b0);
    chk("to_no_tlast", m_tlast, 1'b0);
    tick(); #3;
    chk("to_pulse_end", timeout, 1'b0);
    chk("to_next_grant", grant, 4'b1000);
    chk("to_next_data", m_tdata, 16'hE003);
    tick(); s_tvalid = 4'h0; #3;
    chk("to_next_done", grant, 4'h0);
    rvalid_i = 1'b1; #1;
    chk("rd_route_owner3", rvalid_o, 4'b1000);
    rvalid_i = 1'b0;

    // reset mid-burst after beat 2 of 4
    s_tvalid = 4'b0100; s_tlast = 4'b0000; set_data(2, 16'hF001);
    tick(); #3;
    chk("mrst_grant", grant, 4'b0100);
    chk("mrst_beat1", m_tdata, 16'hF001);
    tick(); set_data(2, 16'hF002); #3;
    chk("mrst_beat2", m_tdata, 16'hF002);
    tick(); set_data(2, 16'hF003); arst = 1'b1; #1;
    chk("mrst_grant_clr", grant, 4'h0);
    chk("mrst_tready", s_tready, 4'h0);
    chk("mrst_mvalid", m_tvalid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    rvalid_i = 1'b1; #1;
    chk("mrst_rvalid", rvalid_o, 4'h0);
    s_tvalid = 4'b0111; s_tlast = 4'b0111;
    tick(); tick(); arst = 1'b0; rvalid_i = 1'b0; #3;
    chk("mrst_idle", grant, 4'h0);
    tick(); #3;
    chk("mrst_restart", grant, 4'b0001);
    tick(); s_tvalid = 4'h0; #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
